// File: rtl/mesh_pkt_pkg.sv
// Shared packet layout, destination check and stall-FSM encoding for the
// mesh_gnrtr terminal injection stage.
package mesh_pkt_pkg;

  localparam int NXT_W   = 8;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 4;
  localparam int MODE_W  = 1;
  localparam int HDR_W   = NXT_W + ROW_W + COL_W + MODE_W;
  localparam int PKT_MAX = 64;

  // Header occupies the top HDR_W bits of every packet, MSB first.
  typedef struct packed {
    logic [NXT_W-1:0] nxt_jump;
    logic [ROW_W-1:0] id_row;
    logic [COL_W-1:0] id_colum;
    logic             mode;
  } pkt_hdr_t;

  function automatic int payload_w(input int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    STALLED = 2'd2
  } stall_st_e;

  // Result is left-aligned at bit pckg_sz-1 inside a PKT_MAX-bit word.
  function automatic logic [PKT_MAX-1:0] pack_pkt(
    input logic [ROW_W-1:0]   row,
    input logic [COL_W-1:0]   col,
    input logic               mode,
    input logic [PKT_MAX-1:0] payload,
    input int                 pckg_sz
  );
    pkt_hdr_t           hdr;
    logic [PKT_MAX-1:0] mask;
    hdr.nxt_jump = '0;
    hdr.id_row   = row;
    hdr.id_colum = col;
    hdr.mode     = mode;
    mask = (64'd1 << payload_w(pckg_sz)) - 64'd1;
    return ({{(PKT_MAX-HDR_W){1'b0}}, hdr} << payload_w(pckg_sz)) | (payload & mask);
  endfunction

  // Only border terminals are addressable; corners and ourselves are not.
  function automatic logic is_valid_dest(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col,
    input int               rows,
    input int               colums,
    input int               self_row,
    input int               self_col
  );
    int  r;
    int  c;
    logic on_row_edge;
    logic on_col_edge;
    r = {28'd0, row};
    c = {28'd0, col};
    on_row_edge = ((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= colums);
    on_col_edge = ((c == 0) || (c == colums + 1)) && (r >= 1) && (r <= rows);
    return (on_row_edge || on_col_edge) && !((r == self_row) && (c == self_col));
  endfunction

endpackage

// File: rtl/mesh_src_fifo.sv
// First-word fall-through FIFO feeding the mesh input port; head reads 0
// while empty.
module mesh_src_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == DEPTH[AW:0]);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = cnt_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mesh_term_src.sv
// Terminal-side injection stage: validates and packs requests, queues them
// for the mesh input port, counts sent/dropped packets and flags a stuck port.
module mesh_term_src
  import mesh_pkt_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int SELF_ROW   = 0,
  parameter int SELF_COL   = 1,
  parameter int STALL_LIM  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [3:0]         req_row,
  input  logic [3:0]         req_col,
  input  logic               req_mode,
  input  logic [pckg_sz-18:0] req_payload,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  output logic [15:0]        sent_cnt,
  output logic [15:0]        drop_cnt,
  output logic               stall,
  output logic [1:0]         dbg_state
);

  localparam int PW = payload_w(pckg_sz);
  localparam int AW = $clog2(fifo_depth);
  localparam int CW = $clog2(STALL_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STALL_LIM);

  typedef struct packed {
    pkt_hdr_t        hdr;
    logic [PW-1:0]   payload;
  } pkt_t;

  // Handshake: a request transfers on a rising edge where req_vld && req_rdy;
  // the mesh consumes the head on a rising edge where popin && pndng_i_in.
  logic [PKT_MAX-1:0] pkt_full;
  pkt_t               push_pkt;
  logic               unused_hi;
  logic               xfer;
  logic               dest_ok;
  logic               push;
  logic               pop_ok;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_cnt;
  logic               stays_busy;
  logic               rdy_en_q;
  logic [15:0]        sent_cnt_q;
  logic [15:0]        drop_cnt_q;
  stall_st_e          state_q;
  logic [CW-1:0]      stall_cnt_q;
  logic               stall_q;

  assign pkt_full  = pack_pkt(req_row, req_col, req_mode,
                              {{(PKT_MAX-PW){1'b0}}, req_payload}, pckg_sz);
  assign push_pkt  = pkt_t'(pkt_full[pckg_sz-1:0]);
  assign unused_hi = ^pkt_full[PKT_MAX-1:pckg_sz];

  assign dest_ok = is_valid_dest(req_row, req_col, ROWS, COLUMS, SELF_ROW, SELF_COL);
  assign req_rdy = rdy_en_q && !fifo_full;
  assign xfer    = req_vld && req_rdy;
  assign push    = xfer && dest_ok;
  assign pop_ok  = popin && !fifo_empty;

  // After a pop the FIFO is still non-empty if more than one entry remains
  // or a new packet lands on the same edge.
  assign stays_busy = push || (fifo_cnt > {{AW{1'b0}}, 1'b1});

  mesh_src_fifo #(
    .W     (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata (push_pkt),
    .pop   (popin),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (data_out_i_in),
    .count (fifo_cnt)
  );

  assign pndng_i_in = !fifo_empty;
  assign sent_cnt   = sent_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign stall      = stall_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en_q   <= 1'b0;
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (pop_ok && (sent_cnt_q != 16'hFFFF)) sent_cnt_q <= sent_cnt_q + 16'd1;
      if (xfer && !dest_ok && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= WAIT;
            stall_cnt_q <= '0;
          end
        end
        WAIT, STALLED: begin
          if (pop_ok) begin
            state_q     <= stays_busy ? WAIT : IDLE;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
          end else if (fifo_empty) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
          end else if (state_q == WAIT) begin
            if (stall_cnt_q == LIM - 1'b1) begin
              state_q     <= STALLED;
              stall_q     <= 1'b1;
            end
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          stall_cnt_q <= '0;
          stall_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_term_src.sv
// Directed bench for mesh_term_src with default parameters (SELF=(0,1),
// 4x4 mesh, depth 4, STALL_LIM 64).
module tb_mesh_term_src;

  localparam int PSZ = 40;
  localparam int PW  = PSZ - 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_vld;
  logic          req_rdy;
  logic [3:0]    req_row;
  logic [3:0]    req_col;
  logic          req_mode;
  logic [PW-1:0] req_payload;
  logic [PSZ-1:0] data_out_i_in;
  logic          pndng_i_in;
  logic          popin;
  logic [15:0]   sent_cnt;
  logic [15:0]   drop_cnt;
  logic          stall;
  logic [1:0]    dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  mesh_term_src dut (
    .clk           (clk),
    .reset         (reset),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_row       (req_row),
    .req_col       (req_col),
    .req_mode      (req_mode),
    .req_payload   (req_payload),
    .data_out_i_in (data_out_i_in),
    .pndng_i_in    (pndng_i_in),
    .popin         (popin),
    .sent_cnt      (sent_cnt),
    .drop_cnt      (drop_cnt),
    .stall         (stall),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [3:0] r, input logic [3:0] c,
                                     input logic m, input logic [PW-1:0] p);
    return {24'd0, 8'd0, r, c, m, p};
  endfunction

  task automatic drive_req(input logic [3:0] r, input logic [3:0] c,
                           input logic m, input logic [PW-1:0] p);
    req_row = r; req_col = c; req_mode = m; req_payload = p;
    req_vld = 1'b1;
  endtask

  // Holds the request until it transfers (bounded), then releases req_vld.
  task automatic send(input logic [3:0] r, input logic [3:0] c, input logic m,
                      input logic [PW-1:0] p, input bit good);
    bit accepted = 1'b0;
    drive_req(r, c, m, p);
    for (int i = 0; i < 20; i++) begin
      if (req_rdy) begin
        accepted = 1'b1;
        break;
      end
      tick();
    end
    if (!accepted) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      tick();
      if (good) exp_q.push_back(mk(r, c, m, p));
    end
    req_vld = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, "_pndng"}, {63'd0, pndng_i_in}, 64'd1);
    if (exp_q.size() > 0) chk({tag, "_head"}, {24'd0, data_out_i_in}, exp_q[0]);
    popin = 1'b1;
    tick();
    popin = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b0; req_vld = 1'b0; req_row = '0; req_col = '0;
    req_mode = 1'b0; req_payload = '0; popin = 1'b0;
    #2;
    chk("rst_pndng", {63'd0, pndng_i_in}, 64'd0);
    chk("rst_data", {24'd0, data_out_i_in}, 64'd0);
    chk("rst_sent", {48'd0, sent_cnt}, 64'd0);
    chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_rdy", {63'd0, req_rdy}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    chk("rdy_after_rel", {63'd0, req_rdy}, 64'd1);

    // basic single packet
    send(4'd5, 4'd2, 1'b1, 23'h15A5A5, 1'b1);
    chk("t1_pndng", {63'd0, pndng_i_in}, 64'd1);
    chk("t1_nxt", {56'd0, data_out_i_in[39:32]}, 64'd0);
    chk("t1_row", {60'd0, data_out_i_in[31:28]}, 64'd5);
    chk("t1_col", {60'd0, data_out_i_in[27:24]}, 64'd2);
    chk("t1_mode", {63'd0, data_out_i_in[23]}, 64'd1);
    chk("t1_payload", {41'd0, data_out_i_in[22:0]}, 64'h15A5A5);
    pop_chk("t1_pop");
    chk("t1_empty", {63'd0, pndng_i_in}, 64'd0);
    chk("t1_sent", {48'd0, sent_cnt}, 64'd1);

    // invalid destinations, and a pop on an empty FIFO
    send(4'd0, 4'd1, 1'b0, 23'h1, 1'b0);
    send(4'd0, 4'd0, 1'b0, 23'h2, 1'b0);
    send(4'd2, 4'd2, 1'b0, 23'h3, 1'b0);
    send(4'd7, 4'd1, 1'b0, 23'h4, 1'b0);
    chk("t2_empty", {63'd0, pndng_i_in}, 64'd0);
    chk("t2_drop", {48'd0, drop_cnt}, 64'd4);
    popin = 1'b1; tick(); popin = 1'b0;
    chk("t2_pop_empty_sent", {48'd0, sent_cnt}, 64'd1);

    // fill to full, fifth held, then released by one pop
    send(4'd0, 4'd2, 1'b0, 23'h000011, 1'b1);
    send(4'd0, 4'd3, 1'b1, 23'h000022, 1'b1);
    send(4'd1, 4'd0, 1'b0, 23'h000033, 1'b1);
    send(4'd2, 4'd5, 1'b1, 23'h000044, 1'b1);
    chk("t3_full_rdy", {63'd0, req_rdy}, 64'd0);
    drive_req(4'd5, 4'd4, 1'b0, 23'h000055);
    tick();
    chk("t3_held_rdy", {63'd0, req_rdy}, 64'd0);
    chk("t3_held_head", {24'd0, data_out_i_in}, exp_q[0]);
    popin = 1'b1;
    tick();
    popin = 1'b0;
    void'(exp_q.pop_front());
    chk("t3_rdy_after_pop", {63'd0, req_rdy}, 64'd1);
    tick();
    exp_q.push_back(mk(4'd5, 4'd4, 1'b0, 23'h000055));
    req_vld = 1'b0;
    chk("t3_full_again", {63'd0, req_rdy}, 64'd0);
    for (int i = 0; i < 4; i++) pop_chk("t3_drain");
    chk("t3_empty", {63'd0, pndng_i_in}, 64'd0);
    chk("t3_sent", {48'd0, sent_cnt}, 64'd6);

    // simultaneous write and pop with two entries queued
    send(4'd3, 4'd0, 1'b0, 23'h0000A1, 1'b1);
    send(4'd4, 4'd5, 1'b1, 23'h0000B2, 1'b1);
    chk("t4_head_a", {24'd0, data_out_i_in}, exp_q[0]);
    drive_req(4'd5, 4'd1, 1'b1, 23'h0000C3);
    popin = 1'b1;
    tick();
    popin = 1'b0;
    req_vld = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(mk(4'd5, 4'd1, 1'b1, 23'h0000C3));
    pop_chk("t4_b");
    pop_chk("t4_c");
    chk("t4_empty", {63'd0, pndng_i_in}, 64'd0);
    chk("t4_sent", {48'd0, sent_cnt}, 64'd9);

    // stall threshold
    send(4'd0, 4'd4, 1'b0, 23'h0000D4, 1'b1);
    repeat (64) tick();
    chk("t5_no_stall_yet", {63'd0, stall}, 64'd0);
    tick();
    chk("t5_stall", {63'd0, stall}, 64'd1);
    chk("t5_state", {62'd0, dbg_state}, 64'd2);
    pop_chk("t5_pop");
    chk("t5_stall_clr", {63'd0, stall}, 64'd0);
    chk("t5_state_idle", {62'd0, dbg_state}, 64'd0);

    // asynchronous reset mid-operation
    send(4'd1, 4'd5, 1'b0, 23'h0000E1, 1'b1);
    send(4'd2, 4'd0, 1'b1, 23'h0000E2, 1'b1);
    send(4'd0, 4'd3, 1'b0, 23'h0000E3, 1'b1);
    send(4'd9, 4'd9, 1'b0, 23'h0000E4, 1'b0);
    repeat (66) tick();
    chk("t6_pre_stall", {63'd0, stall}, 64'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_pndng", {63'd0, pndng_i_in}, 64'd0);
    chk("t6_rst_stall", {63'd0, stall}, 64'd0);
    chk("t6_rst_sent", {48'd0, sent_cnt}, 64'd0);
    chk("t6_rst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("t6_rst_data", {24'd0, data_out_i_in}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    send(4'd5, 4'd3, 1'b1, 23'h7F00FF, 1'b1);
    pop_chk("t6_fresh");
    chk("t6_alone", {63'd0, pndng_i_in}, 64'd0);
    chk("t6_sent", {48'd0, sent_cnt}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mesh_term_src.md
Name: mesh_term_src

Overview:
- Synthesizable terminal-side injection stage for the mesh_gnrtr router mesh.
- One instance sits at each border terminal and sits directly upstream of the mesh's per-terminal input port.
- Accepts destination/mode/payload requests, validates the destination, builds the packet, buffers it in a FIFO, and presents it on the mesh's pending/pop input handshake.
- Also counts sent and dropped packets and flags a stalled mesh port.

Parameters:
- pckg_sz, 40: packet width in bits.
- fifo_depth, 4: injection FIFO entries; power of two, at least 2.
- ROWS, 4: mesh rows.
- COLUMS, 4: mesh columns.
- SELF_ROW, 0: this terminal's row, range 0..ROWS+1.
- SELF_COL, 1: this terminal's column, range 0..COLUMS+1.
- STALL_LIM, 64: cycles a packet may be pending with no pop before stall asserts.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- req_vld, in, 1: request valid.
- req_rdy, out, 1: request ready.
- req_row, in, 4: destination row.
- req_col, in, 4: destination column.
- req_mode, in, 1: routing mode bit.
- req_payload, in, pckg_sz-17: payload.
- data_out_i_in, out, pckg_sz: head packet presented to the mesh.
- pndng_i_in, out, 1: FIFO non-empty.
- popin, in, 1: mesh consumes the head packet.
- sent_cnt, out, 16: packets popped by the mesh.
- drop_cnt, out, 16: requests rejected.
- stall, out, 1: head packet pending longer than STALL_LIM cycles.

Behaviour:
- Packet format, MSB first:
  - Nxt_jump[pckg_sz-1:pckg_sz-8], always 0.
  - id_row[pckg_sz-9:pckg_sz-12].
  - id_colum[pckg_sz-13:pckg_sz-16].
  - mode[pckg_sz-17].
  - payload[pckg_sz-18:0].
- Reset (reset=0, asynchronous):
  - FIFO empty, pointers 0.
  - pndng_i_in=0, data_out_i_in=0.
  - sent_cnt=0, drop_cnt=0, stall=0, FSM in IDLE.
  - req_rdy=0 while reset is held; req_rdy=1 in the first cycle after release.
- Request handshake:
  - req_rdy = !full, combinational from the occupancy count only; it does not look ahead to popin.
  - A transfer occurs on a rising edge with req_vld && req_rdy.
- Destination validity:
  - Valid only if it is a border terminal:
    - (row==0 or row==ROWS+1) with col in 1..COLUMS, or
    - (col==0 or col==COLUMS+1) with row in 1..ROWS.
  - Corners, interior coordinates, out-of-range values and dest==(SELF_ROW,SELF_COL) are invalid.
  - An invalid transferred request is not written to the FIFO; drop_cnt increments by 1, saturating at 0xFFFF.
- FIFO:
  - First-word fall-through; data_out_i_in is always the head entry, or 0 when empty.
  - A write on edge N with the FIFO empty gives pndng_i_in=1 and the packet on data_out_i_in after edge N (latency 1).
  - popin with pndng_i_in=1 advances the head on that edge and increments sent_cnt (saturating).
  - popin while empty is ignored: no pointer or counter change.
  - Simultaneous valid write and pop: both happen and the count is unchanged; when full, req_rdy=0 so no write occurs.
  - Pointers wrap modulo fifo_depth.
- Stall FSM:
  - IDLE: when pndng_i_in=1, go to WAIT with stall counter cleared.
  - WAIT:
    - Counter increments each cycle with pndng_i_in=1 and popin=0.
    - popin returns to IDLE, or restarts WAIT with counter 0 if the FIFO stays non-empty.
    - Counter reaching STALL_LIM goes to STALLED.
  - STALLED:
    - stall=1.
    - popin goes to IDLE or WAIT as above and stall clears on that edge.
    - Requests continue to be accepted while STALLED.
- Reset mid-operation discards FIFO contents and all counters immediately.

Decomposition:
- Package mesh_pkt_pkg holds:
  - field offset/width localparams;
  - the packed packet typedef, parameterized by pckg_sz via a function;
  - pack_pkt(row,col,mode,payload);
  - is_valid_dest(row,col,ROWS,COLUMS,self_row,self_col);
  - stall-FSM state enum {IDLE,WAIT,STALLED}.
- One sub-module mesh_src_fifo: FWFT synchronous FIFO with push, pop, full, empty, head, count.
- Validation, packing, counters and the FSM stay in the top.

Test Plan:
- Reset release, SELF=(0,1): req (row 5,col 2,mode 1,payload 0x15A5A5) -> after 1 edge pndng_i_in=1 and the header fields plus payload decode to those values (Nxt_jump 0); popin 1 cycle -> pndng_i_in=0, sent_cnt=1.
- Invalid destinations (0,1) self, (0,0) corner, (2,2) interior, (7,1) out of range -> each transferred, FIFO stays empty, drop_cnt=4.
- Five valid requests with popin=0, depth 4 -> req_rdy=0 after the fourth; the fifth is held; one popin -> fifth accepted next edge; order preserved on drain; sent_cnt=5.
- FIFO holding 2 entries with simultaneous write and popin -> count stays 2; head changes to the second entry; no loss or duplication.
- One pending packet with popin held 0 and STALL_LIM=64 -> stall=1 on the 64th stall count; popin -> stall=0 on that edge.
- Assert reset with 3 entries queued and stall=1 -> pndng_i_in, stall and counters are 0 asynchronously; after release, a fresh request emerges alone.
